// File: rtl/reg32_uart_dump_if.sv
// Dump port: register value and send request in, UART line and status out.
interface reg32_uart_dump_if;
   logic [31:0] iREG32;
   logic        iSEND;
   logic        oTX;
   logic        oBUSY;
   logic        oDONE;

   modport master (
      output iREG32,
      output iSEND,
      input  oTX,
      input  oBUSY,
      input  oDONE
   );

   modport slave (
      input  iREG32,
      input  iSEND,
      output oTX,
      output oBUSY,
      output oDONE
   );
endinterface

// File: rtl/reg32_uart_dump.sv
// Snapshots a 32-bit register and sends it as 8 uppercase hex chars + CR LF over UART 8N1.
// One cycle from trigger to start bit; requests while busy are dropped, value changes resend on return to idle.
module reg32_uart_dump #(
   parameter int CLKS_PER_BIT = 16,
   parameter bit CHANGE_TRIG  = 1'b1
) (
   input  logic             iCLK,
   input  logic             iRST,
   reg32_uart_dump_if.slave bus
);

   localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [2:0]        bit_idx, bit_idx_nxt;
   logic [3:0]        chr_idx, chr_idx_nxt;
   logic [31:0]       snap, snap_nxt;
   logic [31:0]       last_sent, last_sent_nxt;
   logic [7:0]        shreg, shreg_nxt;
   logic              tx, tx_nxt;
   logic              busy, busy_nxt;
   logic              done, done_nxt;
   logic              trigger;
   logic              bit_end;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      logic [7:0] c;
      if (nib < 4'd10) c = 8'h30 + {4'h0, nib};
      else             c = 8'h37 + {4'h0, nib};
      return c;
   endfunction

   // Characters 0-7 are nibbles MSB first, then CR, LF.
   function automatic logic [7:0] msg_char(input logic [31:0] val, input logic [3:0] idx);
      logic [7:0] c;
      case (idx)
         4'd0:    c = hex_char(val[31:28]);
         4'd1:    c = hex_char(val[27:24]);
         4'd2:    c = hex_char(val[23:20]);
         4'd3:    c = hex_char(val[19:16]);
         4'd4:    c = hex_char(val[15:12]);
         4'd5:    c = hex_char(val[11:8]);
         4'd6:    c = hex_char(val[7:4]);
         4'd7:    c = hex_char(val[3:0]);
         4'd8:    c = 8'h0D;
         default: c = 8'h0A;
      endcase
      return c;
   endfunction

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      bit_idx_nxt   = bit_idx;
      chr_idx_nxt   = chr_idx;
      snap_nxt      = snap;
      last_sent_nxt = last_sent;
      shreg_nxt     = shreg;
      tx_nxt        = tx;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      trigger       = bus.iSEND || (CHANGE_TRIG && (bus.iREG32 != last_sent));
      bit_end       = (cnt == CNT_LAST);

      case (state)
         IDLE: begin
            if (trigger) begin
               snap_nxt      = bus.iREG32;
               last_sent_nxt = bus.iREG32;
               shreg_nxt     = msg_char(bus.iREG32, 4'd0);
               chr_idx_nxt   = 4'd0;
               bit_idx_nxt   = 3'd0;
               cnt_nxt       = '0;
               tx_nxt        = 1'b0;
               busy_nxt      = 1'b1;
               state_nxt     = START;
            end
         end

         START: begin
            if (bit_end) begin
               cnt_nxt     = '0;
               bit_idx_nxt = 3'd0;
               tx_nxt      = shreg[0];
               shreg_nxt   = {1'b0, shreg[7:1]};
               state_nxt   = DATA;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         DATA: begin
            if (bit_end) begin
               cnt_nxt = '0;
               if (bit_idx == 3'd7) begin
                  tx_nxt    = 1'b1;
                  state_nxt = STOP;
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
                  tx_nxt      = shreg[0];
                  shreg_nxt   = {1'b0, shreg[7:1]};
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         STOP: begin
            if (bit_end) begin
               cnt_nxt = '0;
               if (chr_idx == 4'd9) begin
                  // Back to IDLE with DONE; a trigger in this cycle starts the next message.
                  chr_idx_nxt = 4'd0;
                  tx_nxt      = 1'b1;
                  busy_nxt    = 1'b0;
                  done_nxt    = 1'b1;
                  state_nxt   = IDLE;
               end else begin
                  chr_idx_nxt = chr_idx + 4'd1;
                  shreg_nxt   = msg_char(snap, chr_idx + 4'd1);
                  tx_nxt      = 1'b0;
                  state_nxt   = START;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= 3'd0;
         chr_idx   <= 4'd0;
         snap      <= '0;
         last_sent <= '0;
         shreg     <= '0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         chr_idx   <= chr_idx_nxt;
         snap      <= snap_nxt;
         last_sent <= last_sent_nxt;
         shreg     <= shreg_nxt;
         tx        <= tx_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

   assign bus.oTX   = tx;
   assign bus.oBUSY = busy;
   assign bus.oDONE = done;

endmodule

// File: tb/tb_reg32_uart_dump.sv
// Directed bench: four instances covering send/request, change trigger, mid-message reset and bit timing.
module tb_reg32_uart_dump;

   localparam logic [79:0] MSG_12345678 = 80'h3132333435363738_0D0A;
   localparam logic [79:0] MSG_DEADBEEF = 80'h4445414442454546_0D0A;
   localparam logic [79:0] MSG_0000000A = 80'h3030303030303041_0D0A;
   localparam logic [79:0] MSG_0000000B = 80'h3030303030303042_0D0A;
   localparam logic [79:0] MSG_00000000 = 80'h3030303030303030_0D0A;

   logic       iCLK;
   logic [3:0] rst;
   int         n_chk;
   int         n_pass;

   reg32_uart_dump_if b0 ();
   reg32_uart_dump_if b1 ();
   reg32_uart_dump_if b2 ();
   reg32_uart_dump_if b3 ();

   reg32_uart_dump #(.CLKS_PER_BIT(4), .CHANGE_TRIG(1'b0)) u0 (.iCLK(iCLK), .iRST(rst[0]), .bus(b0));
   reg32_uart_dump #(.CLKS_PER_BIT(4), .CHANGE_TRIG(1'b1)) u1 (.iCLK(iCLK), .iRST(rst[1]), .bus(b1));
   reg32_uart_dump #(.CLKS_PER_BIT(2), .CHANGE_TRIG(1'b0)) u2 (.iCLK(iCLK), .iRST(rst[2]), .bus(b2));
   reg32_uart_dump #(.CLKS_PER_BIT(5), .CHANGE_TRIG(1'b0)) u3 (.iCLK(iCLK), .iRST(rst[3]), .bus(b3));

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // {tx, busy, done} of the selected instance
   function automatic logic [2:0] obs(input int sel);
      logic [2:0] o;
      case (sel)
         0:       o = {b0.oTX, b0.oBUSY, b0.oDONE};
         1:       o = {b1.oTX, b1.oBUSY, b1.oDONE};
         2:       o = {b2.oTX, b2.oBUSY, b2.oDONE};
         default: o = {b3.oTX, b3.oBUSY, b3.oDONE};
      endcase
      return o;
   endfunction

   // Called at a negedge. Waits for BUSY, then checks every cycle of the message against the
   // expected waveform, decodes bytes mid-bit, and checks the DONE cycle that follows.
   task automatic capture(input int sel, input int cpb, input logic [79:0] exp_msg,
                          input string tag, output int waited);
      logic [2:0] o;
      logic [7:0] rx [10];
      logic [7:0] eb;
      logic       exp_tx;
      int         wave_err;
      int         busy_low;
      int         done_seen;
      int         ch;
      int         b;
      wave_err  = 0;
      busy_low  = 0;
      done_seen = 0;
      waited    = 0;
      for (int c = 0; c < 10; c++) rx[c] = 8'h00;
      o = obs(sel);
      while (!o[1] && waited < 3000) begin
         @(negedge iCLK);
         waited++;
         o = obs(sel);
      end
      if (!o[1]) begin
         chk({tag, " start timeout"}, 64'd0, 64'd1);
         return;
      end
      for (int i = 0; i < 100 * cpb; i++) begin
         if (i > 0) begin
            @(negedge iCLK);
            o = obs(sel);
         end
         ch = i / (10 * cpb);
         b  = (i % (10 * cpb)) / cpb;
         eb = exp_msg[79 - 8 * ch -: 8];
         if (b == 0)      exp_tx = 1'b0;
         else if (b == 9) exp_tx = 1'b1;
         else             exp_tx = eb[b - 1];
         if (o[2] !== exp_tx) wave_err++;
         if (o[1] !== 1'b1)   busy_low++;
         if (o[0] === 1'b1)   done_seen++;
         if ((i % cpb) == cpb / 2 && b >= 1 && b <= 8) rx[ch][b - 1] = o[2];
      end
      for (int c = 0; c < 10; c++)
         chk($sformatf("%s byte%0d", tag, c), {56'd0, rx[c]}, {56'd0, exp_msg[79 - 8 * c -: 8]});
      chk({tag, " wave errors"}, wave_err, 0);
      chk({tag, " busy low cycles"}, busy_low, 0);
      chk({tag, " early done"}, done_seen, 0);
      @(negedge iCLK);
      o = obs(sel);
      chk({tag, " end {tx,busy,done}"}, {61'd0, o}, 64'b101);
   endtask

   // Counts BUSY and DONE cycles over a window.
   task automatic watch(input int sel, input int cycles, output int busy_n, output int done_n);
      logic [2:0] o;
      busy_n = 0;
      done_n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge iCLK);
         o = obs(sel);
         if (o[1]) busy_n++;
         if (o[0]) done_n++;
      end
   endtask

   initial begin
      int w;
      int bn;
      int dn;
      logic [2:0] o;
      n_chk  = 0;
      n_pass = 0;
      b0.iREG32 = 32'd0; b0.iSEND = 1'b0;
      b1.iREG32 = 32'd0; b1.iSEND = 1'b0;
      b2.iREG32 = 32'd0; b2.iSEND = 1'b0;
      b3.iREG32 = 32'd0; b3.iSEND = 1'b0;
      rst = 4'hF;
      repeat (3) @(negedge iCLK);
      chk("reset u0", {61'd0, obs(0)}, 64'b100);
      chk("reset u1", {61'd0, obs(1)}, 64'b100);
      rst = 4'h0;

      // Basic send
      b0.iREG32 = 32'h1234_5678;
      @(negedge iCLK);
      b0.iSEND = 1'b1;
      fork
         capture(0, 4, MSG_12345678, "basic", w);
         begin
            @(negedge iCLK);
            b0.iSEND = 1'b0;
         end
      join
      chk("basic latency", w, 1);
      @(negedge iCLK);
      chk("basic done one cycle", {63'd0, obs(0) == 3'b100}, 64'd1);

      // Uppercase hex, value changed mid-message
      b0.iREG32 = 32'hDEAD_BEEF;
      b0.iSEND  = 1'b1;
      fork
         capture(0, 4, MSG_DEADBEEF, "hex", w);
         begin
            @(negedge iCLK);
            b0.iSEND = 1'b0;
            repeat (150) @(negedge iCLK);
            b0.iREG32 = 32'd0;
         end
      join

      // Change trigger, dropped request, pending change
      b1.iREG32 = 32'h0000_000A;
      capture(1, 4, MSG_0000000A, "chg A", w);
      watch(1, 200, bn, dn);
      chk("chg hold busy", bn, 0);
      b1.iSEND = 1'b1;
      fork
         capture(1, 4, MSG_0000000A, "req A", w);
         begin
            @(negedge iCLK);
            b1.iSEND = 1'b0;
            repeat (100) @(negedge iCLK);
            b1.iREG32 = 32'h0000_000B;
            repeat (50) @(negedge iCLK);
            b1.iSEND = 1'b1;
            @(negedge iCLK);
            b1.iSEND = 1'b0;
         end
      join
      capture(1, 4, MSG_0000000B, "chg B", w);
      chk("chg B gap", w, 1);
      watch(1, 500, bn, dn);
      chk("chg single B busy", bn, 0);

      // Reset during character 3
      b0.iREG32 = 32'h1234_5678;
      b0.iSEND  = 1'b1;
      @(negedge iCLK);
      b0.iSEND = 1'b0;
      chk("rst busy before", {63'd0, obs(0) == 3'b010}, 64'd1);
      repeat (125) @(negedge iCLK);
      rst[0] = 1'b1;
      @(negedge iCLK);
      rst[0] = 1'b0;
      o = obs(0);
      chk("rst abort {tx,busy,done}", {61'd0, o}, 64'b100);
      watch(0, 500, bn, dn);
      chk("rst no done", dn, 0);
      chk("rst no busy", bn, 0);
      b0.iSEND = 1'b1;
      fork
         capture(0, 4, MSG_12345678, "after rst", w);
         begin
            @(negedge iCLK);
            b0.iSEND = 1'b0;
         end
      join

      // Back-to-back with SEND held, two bit lengths
      b2.iSEND = 1'b1;
      capture(2, 2, MSG_00000000, "b2b c2 #1", w);
      capture(2, 2, MSG_00000000, "b2b c2 #2", w);
      chk("b2b c2 gap", w, 1);
      b2.iSEND = 1'b0;
      b3.iSEND = 1'b1;
      capture(3, 5, MSG_00000000, "b2b c5 #1", w);
      capture(3, 5, MSG_00000000, "b2b c5 #2", w);
      chk("b2b c5 gap", w, 1);
      b3.iSEND = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/reg32_uart_dump.md
# reg32_uart_dump

Downstream consumer of the SoC's 32-bit debug register output (`oREG32`). It snapshots the 32-bit value and transmits it over a single UART TX line as 8 uppercase ASCII hex characters followed by CR LF, so the register value can be read on a host terminal. A transmission starts on an explicit request pulse and, optionally, whenever the value differs from the last one sent. The block is instantiated beside `soc_riscv_32i` at board top level and shares its clock and reset.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal range is 2 or more.
- `CHANGE_TRIG`, default 1: when 1, a value differing from the last one sent starts a transmission automatically.

Ports:
- `iCLK`  in  1  system clock. This is the only clock.
- `iRST`  in  1  synchronous, active-high reset.
- `iREG32`  in  32  value to dump. Connects to the SoC `oREG32`.
- `iSEND`  in  1  request pulse. It is sampled every cycle.
- `oTX`  out  1  UART serial output. Idle level is 1.
- `oBUSY`  out  1  high while a message is in flight.
- `oDONE`  out  1  one-cycle pulse when the message completes.

## Operation
- **States:** IDLE, START, DATA, STOP. Registers:
  - bit-cycle counter, width clog2(CLKS_PER_BIT)
  - bit index, 0–7
  - character index, 0–9
  - 32-bit snapshot
  - 32-bit `last_sent`
  - 8-bit shift register
- **Trigger:** evaluated only in IDLE. trigger = `iSEND` OR (`CHANGE_TRIG` AND `iREG32` != `last_sent`).
- **On trigger:**
  - snapshot and `last_sent` both load `iREG32`.
  - character 0 is loaded into the shift register.
  - the state goes to START.
- **Message:** 10 characters, in this order:
  - characters 0–7 are the snapshot nibbles, MSB nibble first. Nibble 0–9 maps to 0x30–0x39; nibble A–F maps to 0x41–0x46 (uppercase).
  - character 8 is 0x0D.
  - character 9 is 0x0A.
- **Character frame:** 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- **Sequencing:**
  - there is no idle gap between characters; the next start bit follows the stop bit immediately.
  - after the stop bit of character 9 the state returns to IDLE.
- **Triggers while not IDLE:**
  - an `iSEND` pulse is dropped; requests are not queued.
  - `iREG32` changes are not lost. `last_sent` is compared again on return to IDLE, so the latest differing value is sent once.
- **`iREG32` stability:** `iREG32` may change at any time during a transmission. The snapshot alone is transmitted.
- **Reset:**
  - `oTX`=1, `oBUSY`=0, `oDONE`=0.
  - `last_sent`=0, all counters 0, state IDLE.
  - with `CHANGE_TRIG`=1, a nonzero `iREG32` after reset triggers a send.
- **Reset mid-message:** the message aborts. On the next edge `oTX`=1 and `oBUSY`=0, and no `oDONE` is produced.

## Timing
- **Outputs:** all outputs are registered; none is combinational from inputs.
- **Start:** trigger sampled at edge k drives `oTX`=0 and `oBUSY`=1 from edge k onward. That is 1 cycle of latency from the request.
- **Message length:** exactly 100·`CLKS_PER_BIT` cycles. Edge k+100·`CLKS_PER_BIT` sets:
  - `oBUSY`=0
  - `oDONE`=1 for one cycle
  - `oTX`=1 (idle)
- **Back-to-back:** in the `oDONE` cycle the block is IDLE, so a trigger there starts the next message at the following edge. Minimum idle time between messages is 1 cycle.
- **Signal behaviour during a message:**
  - `oTX` changes only on bit boundaries.
  - `oBUSY` stays continuously high.

## Test plan
1. **Basic send:** `CLKS_PER_BIT`=4, `CHANGE_TRIG`=0, `iREG32`=0x12345678, 1-cycle `iSEND`.
   - Decoded bytes: 0x31 0x32 0x33 0x34 0x35 0x36 0x37 0x38 0x0D 0x0A.
   - `oBUSY` is high for exactly 400 cycles.
   - exactly one `oDONE` pulse, coincident with `oBUSY` falling.
2. **Uppercase hex:** `iREG32`=0xDEADBEEF, `iSEND`.
   - Decoded bytes: 0x44 0x45 0x41 0x44 0x42 0x45 0x45 0x46 0x0D 0x0A.
   - `iREG32` is changed to 0 mid-message and the output is unaffected.
3. **Dropped request and change trigger:** `CHANGE_TRIG`=1.
   - After reset, `iREG32`=0x0000000A, which sends "0000000A\r\n". Holding the value produces no further message.
   - Set 0x0000000B mid-message and pulse `iSEND` mid-message: after `oDONE`, exactly one message "0000000B\r\n" follows.
4. **Reset mid-message:** assert `iRST` for 1 cycle during character 3.
   - Next cycle `oTX`=1, `oBUSY`=0, `oDONE` never pulses.
   - A subsequent `iSEND` produces a complete, correct message.
5. **Back-to-back:** `iSEND` held high continuously with `CHANGE_TRIG`=0 and `iREG32`=0.
   - Messages "00000000\r\n" repeat, each with a 1-cycle IDLE gap.
   - Each frame bit is exactly `CLKS_PER_BIT` cycles, checked at `CLKS_PER_BIT`=2 and 5.
